// File: rtl/adder_share_ctrl.sv
// -----------------------------------------------------------------------------
// adder_share_ctrl
//
// Purpose:
//   Shares one 5-bit combinational adder between two requesters. A requester
//   raises req with its operands. The block grants one requester at a time and
//   latches that requester's operands into the operand registers feeding the
//   adder. It captures the 6-bit {cout, sum} result and pulses a one-cycle done
//   to that requester. Each operation takes IDLE -> ADD -> DONE, which is three
//   cycles.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst      in   1  synchronous, active-high reset
//   req      in   2  request per requester (bit N = requester N)
//   a0, b0   in   5  requester 0 operands
//   a1, b1   in   5  requester 1 operands
//   gnt      out  2  one-hot grant, high during ADD and DONE
//   done     out  2  one-cycle pulse to the granted requester, res valid
//   res      out  6  {cout, sum} of the last completed operation
//   busy     out  1  high whenever the sequencer is not IDLE
//
// Configuration:
//   ADDER_SHARE_FIXED_PRIO_EN  defined   -> requester 0 always wins a tie
//                              undefined -> round-robin via priority pointer
// -----------------------------------------------------------------------------

module adder (
  input  logic [4:0] a,
  input  logic [4:0] b,
  output logic [4:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

module adder_share_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [4:0] a0,
  input  logic [4:0] b0,
  input  logic [4:0] a1,
  input  logic [4:0] b1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [5:0] res,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q,   gnt_d;
  logic [1:0] done_q,  done_d;
  logic [5:0] res_q,   res_d;
  logic [4:0] opa_q,   opa_d;
  logic [4:0] opb_q,   opb_d;
`ifndef ADDER_SHARE_FIXED_PRIO_EN
  logic       ptr_q,   ptr_d;
`endif

  logic       win_s;
  logic [4:0] sum_s;
  logic       cout_s;

  // The shared adder only ever sees the latched operands, never the raw inputs.
  adder u_adder (
    .a    (opa_q),
    .b    (opb_q),
    .sum  (sum_s),
    .cout (cout_s)
  );

`ifdef ADDER_SHARE_FIXED_PRIO_EN
  // Winner selection: requester 0 has fixed priority over requester 1.
  always_comb begin
    win_s = 1'b0;
    if (req[0]) begin
      win_s = 1'b0;
    end else begin
      win_s = 1'b1;
    end
  end
`else
  // Winner selection: ptr breaks ties, and a lone requester always wins.
  always_comb begin
    win_s = 1'b0;
    if (req == 2'b11) begin
      win_s = ptr_q;
    end else if (req[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end
`endif

  // Next-state and datapath-register logic for the IDLE/ADD/DONE sequencer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    res_d   = res_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
`ifndef ADDER_SHARE_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        // req is only looked at here, so requests raised mid-operation wait.
        if (req != 2'b00) begin
          state_d = ADD;
          if (win_s) begin
            gnt_d = 2'b10;
            opa_d = a1;
            opb_d = b1;
          end else begin
            gnt_d = 2'b01;
            opa_d = a0;
            opb_d = b0;
          end
`ifndef ADDER_SHARE_FIXED_PRIO_EN
          ptr_d = ~win_s;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        // Completion does not depend on req: a dropped request still finishes.
        state_d = DONE;
        res_d   = {cout_s, sum_s};
        done_d  = gnt_q;
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      res_q   <= 6'd0;
      opa_q   <= 5'd0;
      opb_q   <= 5'd0;
`ifndef ADDER_SHARE_FIXED_PRIO_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
`ifndef ADDER_SHARE_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign res  = res_q;
  assign busy = (state_q != IDLE);

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Sequencer and round-robin arbiter that shares one instance of the 5-bit `adder` (a, b → sum, cout) between two requesters. Each requester raises a request with its operands; the block grants one at a time, latches that requester's operands into the shared adder, captures the 6-bit result, and pulses a per-requester done. It sits between the lab's operand sources and the single combinational adder, so one adder serves both clients without contention.

## Interface
- Parameters: none. Operand width is fixed at 5 bits by the shared `adder`.
- `clk` input 1: system clock, rising edge. The block uses one clock.
- `rst` input 1: reset, synchronous and active-high.
- `req` input 2: request per requester (bit 0 = requester 0, bit 1 = requester 1).
- `a0`, `b0` input 5 each: requester 0 operands.
- `a1`, `b1` input 5 each: requester 1 operands.
- `gnt` output 2: one-hot grant, high for the granted requester during ADD and DONE.
- `done` output 2: one-cycle pulse to the granted requester when `res` is valid.
- `res` output 6: `{cout, sum}` of the last completed operation. Holds its value until the next DONE.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Internal `adder` instance, driven only from the operand registers `opa` and `opb`.
- State machine:
  - IDLE → ADD when any `req` bit is 1. The winner is chosen, `gnt` is set, and `opa`/`opb` are loaded from the winner's operands.
  - IDLE → IDLE when `req` is 0.
  - ADD → DONE, unconditionally. `res` is loaded with `{cout, sum}` and `done[winner]` is set.
  - DONE → IDLE, unconditionally. `gnt` and `done` are cleared.
- Arbitration is round-robin. A priority pointer `ptr` (1 bit) names the preferred requester.
  - If both requesters request, `ptr` wins. After every grant, `ptr` is set to the non-winner.
  - If only one requester requests, it wins regardless of `ptr`.
- Operands are latched at grant. The requester may change `aN`/`bN` freely after seeing `gnt`.
- A requester must hold `req` high until its `done`. Dropping `req` during ADD or DONE has no effect: the operation completes and `done` still pulses.
- `req` still high in the IDLE cycle after DONE counts as a new request.
- `req` is sampled only in IDLE. Requests arriving in ADD or DONE wait, with no loss.
- Arithmetic: `res = aN + bN`, zero-extended to 6 bits. Range 0..62, and the carry goes to `res[5]`.
- Reset values: state IDLE, `gnt` = 0, `done` = 0, `res` = 0, `busy` = 0, `ptr` = 0, `opa` = `opb` = 0.
- Reset mid-operation: the operation is aborted, no `done` is issued, `res` keeps its reset value of 0, and the next cycle is IDLE.

## Timing
- Cycle n (IDLE, `req` sampled) → cycle n+1: ADD, `gnt` high → cycle n+2: DONE, `done` pulse, `res` valid → cycle n+3: IDLE.
- Latency is 2 cycles from the sampling edge to `done`.
- Throughput is one operation per 3 cycles.
- With both requesters continuously requesting, grants alternate 0, 1, 0, 1, … with a 3-cycle period, starting with requester 0 after reset.
- `done` and `gnt` are registered outputs. There is no combinational path from `req` to any output.
- `res` changes only on the edge entering DONE, or on reset.

## Configuration
- `ADDER_SHARE_FIXED_PRIO_EN`:
  - Defined: fixed priority. Requester 0 always wins when both request, and `ptr` is neither used nor updated. Requester 1 may starve.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then `req` = 2'b01 with `a0` = 5, `b0` = 7 → `gnt` = 01 in cycle n+1, `done` = 01 with `res` = 12 in cycle n+2, `busy` = 0 in cycle n+3.
- Overflow boundary: `a1` = 31, `b1` = 31, `req` = 2'b10 → `res` = 62 (6'b111110). Also `a1` = 31, `b1` = 1 → `res` = 32. Also `a1` = 0, `b1` = 0 → `res` = 0.
- Both requesters held high for 4 operations (`a0` = 1, `b0` = 2; `a1` = 10, `b1` = 20) → `done` sequence 01, 10, 01, 10 with `res` 3, 30, 3, 30, one `done` every 3 cycles. With `ADDER_SHARE_FIXED_PRIO_EN` defined → `done` = 01 every time.
- Operands changed and `req` dropped the cycle after `gnt` → `res` still reflects the latched operands and `done` still pulses.
- Assert `rst` during ADD → no `done`, `gnt` = 0, `res` = 0 next cycle. A following request completes normally, and requester 0 is preferred.
- Exhaustive sweep of all 32×32 operand pairs through requester 0 → every `res` equals `a0 + b0`, and the bench reports pass or fail.
